mult_sequencer: RTL and testbench

Iterative shift-add multiply controller for the EX stage of the pipelined DLX core. Accepts a multiply issued from the decoded Mult-class opcode, runs one partial-product step per cycle, and holds the pipeline via `stall` until the 64-bit product is ready. It sits beside the ALU: the EX-stage mux selects `result_lo` when `done` pulses. It also honours the EX-stage flush raised by branch, jump or JR resolution.

---
 rtl/dlx_pkg.sv | 28 ++
 rtl/mult_shift_add_dp.sv | 72 +++++++
 rtl/mult_sequencer.sv | 120 ++++++++++++
 tb/tb_mult_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX definitions used by the EX-stage multiply sequencer and by the
// control decoder that drives it.
//   - mult_state_t : sequencer FSM states {IDLE, RUN, DONE}
//   - MULT_W       : default multiply operand width
//   - FUNCT_MULT / FUNCT_MULTU : Mult-class R-type funct codes; control uses
//     them to raise start and is_signed
package dlx_pkg;

    localparam int MULT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam logic [5:0] FUNCT_MULT  = 6'h0E;
    localparam logic [5:0] FUNCT_MULTU = 6'h16;

    function automatic logic is_mult_funct(input logic [5:0] funct);
        return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
    endfunction

    function automatic logic mult_funct_signed(input logic [5:0] funct);
        return funct == FUNCT_MULT;
    endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-add multiply datapath: accumulator, adder and shifter.
// Optional feature macro: MULT_SIGNED_EN (keeps a sign flag and negates the
// final product when it is set).
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   load         : capture multiplicand, multiplier and sign; clear acc
//   step         : perform one add-and-shift step
//   negate       : this step is the last one; negate product if sign set
//   sign_in      : product sign to record on load
//   mcand_in     : multiplicand magnitude
//   mplier_in    : multiplier magnitude
//   product      : combinational value of the product after this step
module mult_shift_add_dp
    import dlx_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 negate,
    input  logic                 sign_in,
    input  logic [WIDTH-1:0]     mcand_in,
    input  logic [WIDTH-1:0]     mplier_in,
    output logic [2*WIDTH-1:0]   product
);

    // {carry, acc_hi, acc_lo}; acc_lo starts as the multiplier and is
    // consumed LSB-first while product bits shift in from the top.
    logic [2*WIDTH:0]   acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   acc_step;

    always_comb begin
        sum      = acc[2*WIDTH:WIDTH] + {1'b0, (acc[0] ? mcand : '0)};
        acc_step = {1'b0, sum, acc[WIDTH-1:1]};
    end

`ifdef MULT_SIGNED_EN
    logic sign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    sign_q <= 1'b0;
        else if (load) sign_q <= sign_in;
    end

    always_comb begin
        product = acc_step[2*WIDTH-1:0];
        if (negate && sign_q) product = -acc_step[2*WIDTH-1:0];
    end
`else
    // Unsigned-only build: sign inputs have no consumer.
    logic unused_sign;
    assign unused_sign = negate ^ sign_in;
    assign product     = acc_step[2*WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            mcand <= '0;
        end else if (load) begin
            acc   <= {1'b0, {WIDTH{1'b0}}, mplier_in};
            mcand <= mcand_in;
        end else if (step) begin
            acc   <= acc_step;
        end
    end

endmodule

// File: rtl/mult_sequencer.sv
// Iterative shift-add multiply controller for the DLX EX stage. One partial
// product per cycle; stalls the pipeline until the 2*WIDTH product is ready.
// Optional feature macro: MULT_SIGNED_EN (signed multiply via magnitudes and
// a final negate; without it is_signed is ignored).
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   start                : multiply present in EX this cycle
//   is_signed            : signed multiply requested
//   op_a, op_b           : multiplicand, multiplier
//   flush                : EX-stage flush
//   stall                : freeze IF/ID/EX registers
//   busy                 : FSM not IDLE
//   done                 : one-cycle result-valid pulse
//   result_lo, result_hi : product halves, held until the next DONE
module mult_sequencer
    import dlx_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
);

    localparam int CW = $clog2(WIDTH);

    mult_state_t           state, next_state;
    logic [CW-1:0]         count;
    logic                  accept, last, load, step, finish;
    logic [WIDTH-1:0]      a_mag, b_mag;
    logic                  sign_in;
    logic [2*WIDTH-1:0]    product;

`ifdef MULT_SIGNED_EN
    logic neg_a, neg_b;
    always_comb begin
        neg_a   = is_signed && op_a[WIDTH-1];
        neg_b   = is_signed && op_b[WIDTH-1];
        a_mag   = neg_a ? -op_a : op_a;
        b_mag   = neg_b ? -op_b : op_b;
        sign_in = neg_a ^ neg_b;
    end
`else
    logic unused_signed;
    assign unused_signed = is_signed;
    assign a_mag   = op_a;
    assign b_mag   = op_b;
    assign sign_in = 1'b0;
`endif

    assign accept = (state == IDLE) && start && !flush;
    assign last   = (count == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; flush in RUN abandons the multiply
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = RUN;
            RUN:     if (flush)  next_state = IDLE;
                     else if (last) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output / strobe logic
    always_comb begin
        stall  = accept || (state == RUN);
        busy   = (state != IDLE);
        done   = (state == DONE);
        load   = accept;
        step   = (state == RUN) && !flush;
        finish = step && last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     count <= '0;
        else if (load)  count <= '0;
        else if (step)  count <= count + 1'b1;
    end

    // Capture on the RUN-to-DONE edge so result_* are valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_lo <= '0;
            result_hi <= '0;
        end else if (finish) begin
            result_lo <= product[WIDTH-1:0];
            result_hi <= product[2*WIDTH-1:WIDTH];
        end
    end

    mult_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .negate    (finish),
        .sign_in   (sign_in),
        .mcand_in  (a_mag),
        .mplier_in (b_mag),
        .product   (product)
    );

endmodule

// File: tb/tb_mult_sequencer.sv
module tb_mult_sequencer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          is_signed = 1'b0;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic          flush = 1'b0;
    logic          stall, busy, done;
    logic [W-1:0]  result_lo, result_hi;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Reference product: plain 64-bit multiply of (sign-extended) operands.
    function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
        logic [63:0] xa, xb;
        xa = {32'b0, a};
        xb = {32'b0, b};
`ifdef MULT_SIGNED_EN
        if (s) begin
            xa = {{32{a[W-1]}}, a};
            xb = {{32{b[W-1]}}, b};
        end
`else
        if (s) xa = xa;
`endif
        return xa * xb;
    endfunction

    // Timeline model: phase 0 idle, 1..W multiply in flight, W+1 result cycle.
    int          phase;
    logic [63:0] m_res, m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= 0;
            m_res  <= '0;
            m_pend <= '0;
        end else if (phase == 0) begin
            if (start && !flush) begin
                phase  <= 1;
                m_pend <= ref_prod(op_a, op_b, is_signed);
            end
        end else if (phase <= W) begin
            if (flush) phase <= 0;
            else begin
                phase <= phase + 1;
                if (phase == W) m_res <= m_pend;
            end
        end else begin
            phase <= 0;
        end
    end

    always @(negedge clk) begin
        check("stall", {63'b0, stall}, {63'b0, (phase == 0 && start && !flush) || (phase >= 1 && phase <= W)});
        check("busy",  {63'b0, busy},  {63'b0, phase != 0});
        check("done",  {63'b0, done},  {63'b0, phase == W + 1});
        check("result", {result_hi, result_lo}, m_res);
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(posedge clk); #1;
        start = 1'b1; op_a = a; op_b = b; is_signed = s;
    endtask

    // Called in the start cycle; counts stall cycles and done latency.
    // inj >= 1 re-raises start with op_a=9 during that RUN cycle.
    task automatic wait_done(input int inj, output int stalls, output int lat);
        bit got;
        got = 0; stalls = 0; lat = -1;
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            if (i > 0) @(negedge clk);
            if (stall) stalls++;
            if (done) begin lat = i; got = 1; break; end
            if (i == 0 || i == inj + 1) begin
                @(posedge clk); #1; start = 1'b0;
            end else if (i == inj) begin
                @(posedge clk); #1; start = 1'b1; op_a = 9;
            end
        end
        if (!got) check("done_timeout", 64'd0, 64'd1);
    endtask

    int stalls, lat, dcnt;
    logic [W-1:0] prior_lo;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_result", {result_hi, result_lo}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        // Basic 7*6
        issue(7, 6, 1'b0);
        wait_done(-1, stalls, lat);
        check("basic_stalls", 64'(stalls), 64'd33);
        check("basic_latency", 64'(lat), 64'd33);
        check("basic_lo", {32'b0, result_lo}, 64'd42);
        check("basic_hi", {32'b0, result_hi}, 64'd0);
        @(negedge clk);
        check("basic_busy_after", {63'b0, busy}, 64'd0);

        // Unsigned overflow
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(-1, stalls, lat);
        check("ovf_prod", {result_hi, result_lo}, 64'hFFFF_FFFE_0000_0001);

        // -3 * 5 with is_signed
        issue(32'hFFFF_FFFD, 32'd5, 1'b1);
        wait_done(-1, stalls, lat);
`ifdef MULT_SIGNED_EN
        check("signed_prod", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
`else
        check("signed_prod", {result_hi, result_lo}, 64'h0000_0004_FFFF_FFF1);
`endif
        is_signed = 1'b0;

        // Flush on RUN cycle 10
        prior_lo = result_lo;
        issue(7, 6, 1'b0);
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy", {63'b0, busy}, 64'd0);
        check("flush_stall", {63'b0, stall}, 64'd0);
        dcnt = 0;
        repeat (40) begin @(negedge clk); if (done) dcnt++; end
        check("flush_no_done", 64'(dcnt), 64'd0);
        check("flush_keep_lo", {32'b0, result_lo}, {32'b0, prior_lo});

        // start during RUN is ignored
        issue(7, 6, 1'b0);
        wait_done(3, stalls, lat);
        check("busy_start_prod", {result_hi, result_lo}, 64'd42);
        check("busy_start_latency", 64'(lat), 64'd33);

        // start + flush together in IDLE
        @(posedge clk); #1 start = 1'b1; flush = 1'b1; op_a = 5; op_b = 5;
        @(negedge clk);
        check("coll_stall", {63'b0, stall}, 64'd0);
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("coll_busy", {63'b0, busy}, 64'd0);

        // Reset at RUN cycle 5
        issue(9, 9, 1'b0);
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_zero", {result_hi, result_lo, 29'b0, stall, busy, done}, 128'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        dcnt = 0;
        repeat (40) begin @(negedge clk); if (done) dcnt++; end
        check("mid_rst_no_done", 64'(dcnt), 64'd0);

        issue(3, 4, 1'b0);
        wait_done(-1, stalls, lat);
        check("post_rst_prod", {result_hi, result_lo}, 64'd12);

        // Pin the reference model itself
        check("model_7x6", ref_prod(7, 6, 1'b0), 64'd42);
        check("model_ovf", ref_prod(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0), 64'hFFFF_FFFE_0000_0001);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
